// File: rtl/rr_stream_arb2.sv
// Two-channel round-robin stream arbiter with packet lock and a registered output stage.
// The output register's source channel is exported as sel for a downstream 2:1 mux.
module rr_stream_arb2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             sel
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]       state;
    logic             prio;
    logic             grant_vld;
    logic             grant_ch;
    logic             reg_free;
    logic             acc_valid;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;
    logic             accept;

    // Grant is fixed while a packet is in flight; otherwise round-robin on prio.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = 1'b0;
        case (state)
            LOCK0: begin
                grant_vld = 1'b1;
                grant_ch  = 1'b0;
            end
            LOCK1: begin
                grant_vld = 1'b1;
                grant_ch  = 1'b1;
            end
            default: begin
                if (in0_valid && in1_valid) begin
                    grant_vld = 1'b1;
                    grant_ch  = prio;
                end else if (in0_valid) begin
                    grant_vld = 1'b1;
                    grant_ch  = 1'b0;
                end else if (in1_valid) begin
                    grant_vld = 1'b1;
                    grant_ch  = 1'b1;
                end
            end
        endcase
    end

    assign reg_free  = !out_valid || out_ready;
    assign in0_ready = grant_vld && !grant_ch && reg_free;
    assign in1_ready = grant_vld &&  grant_ch && reg_free;

    assign acc_valid = grant_ch ? in1_valid : in0_valid;
    assign acc_last  = grant_ch ? in1_last  : in0_last;
    assign acc_data  = grant_ch ? in1_data  : in0_data;
    assign accept    = grant_vld && reg_free && acc_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            sel       <= 1'b0;
            state     <= IDLE;
            prio      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= acc_data;
            out_last  <= acc_last;
            sel       <= grant_ch;
            if (acc_last) begin
                state <= IDLE;
                prio  <= ~grant_ch;
            end else begin
                state <= grant_ch ? LOCK1 : LOCK0;
            end
        end else if (out_ready) begin
            // Drained with nothing to refill: data/last/sel keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_arb2.sv
// Bench for rr_stream_arb2: directed scenarios plus random traffic, one 32-bit and one 8-bit
// instance sharing stimulus, checked against a transaction-level model and per-channel scoreboard.
module tb_rr_stream_arb2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in0_valid, in0_last, in1_valid, in1_last, out_ready;
    logic [31:0] in0_data, in1_data;

    logic        r0_32, r1_32, ov_32, ol_32, sel_32;
    logic [31:0] od_32;
    logic        r0_8, r1_8, ov_8, ol_8, sel_8;
    logic [7:0]  od_8;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_stream_arb2 #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(r0_32),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(r1_32),
        .out_valid(ov_32), .out_data(od_32), .out_last(ol_32), .out_ready(out_ready), .sel(sel_32)
    );

    rr_stream_arb2 #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in0_valid(in0_valid), .in0_data(in0_data[7:0]), .in0_last(in0_last), .in0_ready(r0_8),
        .in1_valid(in1_valid), .in1_data(in1_data[7:0]), .in1_last(in1_last), .in1_ready(r1_8),
        .out_valid(ov_8), .out_data(od_8), .out_last(ol_8), .out_ready(out_ready), .sel(sel_8)
    );

    // Reference model: owner = channel holding an open packet (-1 none), plus output register.
    bit          known = 0;
    int          owner, prio;
    bit          m_ov, m_ol;
    int          m_sel;
    logic [31:0] m_od;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int          pkt_open;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic iv0, input logic [31:0] id0, input logic il0,
                         input logic iv1, input logic [31:0] id1, input logic il1,
                         input logic iordy, input logic irst_n);
        int          g;
        bit          fr, acc;
        logic [32:0] exp_beat;
        in0_valid = iv0; in0_data = id0; in0_last = il0;
        in1_valid = iv1; in1_data = id1; in1_last = il1;
        out_ready = iordy; rst_n = irst_n;
        @(negedge clk);
        if (owner >= 0)        g = owner;
        else if (iv0 && iv1)   g = prio;
        else if (iv0)          g = 0;
        else if (iv1)          g = 1;
        else                   g = -1;
        fr  = !m_ov || iordy;
        acc = fr && ((g == 0 && iv0) || (g == 1 && iv1));
        if (known) begin
            chk("in0_ready", r0_32, fr && g == 0);
            chk("in1_ready", r1_32, fr && g == 1);
            chk("one_hot_ready", r0_32 && r1_32, 1'b0);
            chk("out_valid", ov_32, m_ov);
            chk("w8_in0_ready", r0_8, fr && g == 0);
            chk("w8_in1_ready", r1_8, fr && g == 1);
            chk("w8_out_valid", ov_8, m_ov);
            if (m_ov) begin
                chk("out_data", od_32, m_od);
                chk("out_last", ol_32, m_ol);
                chk("sel", sel_32, m_sel[0]);
                chk("w8_out_data", od_8, m_od[7:0]);
                chk("w8_sel", sel_8, m_sel[0]);
            end
            // Scoreboard on the DUT's own output: order per channel and no interleaving.
            if (irst_n && ov_32 && iordy) begin
                if (sel_32 === 1'b1 && q1.size() > 0)      exp_beat = q1.pop_front();
                else if (sel_32 === 1'b0 && q0.size() > 0) exp_beat = q0.pop_front();
                else                                       exp_beat = 33'h1_dead_beef;
                chk("order_beat", {ol_32, od_32}, exp_beat);
                if (pkt_open >= 0) chk("no_interleave", sel_32, pkt_open[0]);
                pkt_open = ol_32 ? -1 : int'(sel_32);
            end
        end
        if (!irst_n) begin
            known = 1; owner = -1; prio = 0;
            m_ov = 0; m_od = '0; m_ol = 0; m_sel = 0;
            q0.delete(); q1.delete(); pkt_open = -1;
        end else if (acc) begin
            m_ov = 1; m_sel = g;
            m_od = (g == 1) ? id1 : id0;
            m_ol = (g == 1) ? il1 : il0;
            if (g == 1) q1.push_back({il1, id1});
            else        q0.push_back({il0, id0});
            if (m_ol) begin owner = -1; prio = 1 - g; end
            else      owner = g;
        end else if (iordy) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        owner = -1; prio = 0; pkt_open = -1;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 1, 1);
            chk("idle_out_valid", ov_32, 1'b0);
            chk("idle_sel", sel_32, 1'b0);
            chk("idle_readys", {r0_32, r1_32}, 2'b00);
        end

        // Single-beat packets on both channels alternate
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1, 32'hA1, 1, 1, 32'hB2, 1, 1, 1);
            chk("alt_data", od_32, (i % 2 == 0) ? 32'hA1 : 32'hB2);
            chk("alt_sel", sel_32, (i % 2 == 0) ? 1'b0 : 1'b1);
        end

        // Packet lock on ch0 while ch1 waits
        do_reset();
        cycle(1, 32'h10, 0, 1, 32'h20, 1, 1, 1);
        chk("lock_d0", od_32, 32'h10);
        chk("lock_in1_ready", r1_32, 1'b0);
        cycle(1, 32'h11, 0, 1, 32'h20, 1, 1, 1);
        chk("lock_d1", od_32, 32'h11);
        chk("lock_in1_ready", r1_32, 1'b0);
        cycle(0, 32'h12, 1, 1, 32'h20, 1, 1, 1);
        chk("lock_gap_out_valid", ov_32, 1'b0);
        chk("lock_gap_in1_ready", r1_32, 1'b0);
        cycle(1, 32'h12, 1, 1, 32'h20, 1, 1, 1);
        chk("lock_d2", od_32, 32'h12);
        cycle(0, 0, 0, 1, 32'h20, 1, 1, 1);
        chk("lock_after_data", od_32, 32'h20);
        chk("lock_after_sel", sel_32, 1'b1);

        // Backpressure with 0x55 buffered
        do_reset();
        cycle(1, 32'h55, 1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 32'h66, 1, 1, 32'h77, 1, 0, 1);
            chk("bp_data", od_32, 32'h55);
            chk("bp_valid", ov_32, 1'b1);
            chk("bp_readys", {r0_32, r1_32}, 2'b00);
        end
        cycle(1, 32'h66, 1, 1, 32'h77, 1, 1, 1);
        chk("bp_next_data", od_32, 32'h77);
        chk("bp_next_sel", sel_32, 1'b1);
        cycle(1, 32'h66, 1, 0, 0, 0, 1, 1);
        chk("bp_next2_data", od_32, 32'h66);
        cycle(0, 0, 0, 0, 0, 0, 1, 1);

        // Reset in the middle of a ch1 packet
        do_reset();
        cycle(0, 0, 0, 1, 32'h31, 0, 1, 1);
        chk("mid_d", od_32, 32'h31);
        cycle(0, 0, 0, 1, 32'h32, 0, 1, 0);
        chk("mid_rst_valid", ov_32, 1'b0);
        chk("mid_rst_data", od_32, 32'h0);
        chk("mid_rst_sel", sel_32, 1'b0);
        cycle(1, 32'h40, 1, 1, 32'h41, 1, 1, 1);
        chk("mid_after_sel", sel_32, 1'b0);
        chk("mid_after_data", od_32, 32'h40);

        // Random traffic
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 1), $urandom(), ($urandom_range(0, 2) == 0),
                  $urandom_range(0, 1), $urandom(), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) != 0), 1);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0, 1, 1);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
